// File: rtl/serial_frame_pkg.sv
// Shared definitions for the serial frame decoder: frame geometry,
// bit positions inside the 11-bit window, FSM state type and a byte
// bit-reversal helper.
package serial_frame_pkg;

  localparam int FRAME_W      = 11;
  localparam int START_IDX    = 10;
  localparam int DATA_MSB_IDX = 9;
  localparam int DATA_LSB_IDX = 2;
  localparam int PAR_IDX      = 1;
  localparam int STOP_IDX     = 0;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2
  } dec_state_t;

  // The window holds d0 at the highest data index, so the byte comes out mirrored.
  function automatic logic [7:0] reverse8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) begin
      r[i] = v[7 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/serial_frame_decoder_byte_fifo.sv
// Small synchronous FIFO holding decoded bytes. A pop on a full FIFO
// frees the slot in the same cycle, so a simultaneous push is accepted.
// Pops on an empty FIFO and pushes on a full FIFO without a pop are ignored.
module byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap naturally because DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/serial_frame_decoder.sv
// Serial frame decoder: watches the 11-bit shift-register window, finds
// start bits, waits for a full frame, validates it and buffers good bytes.
// Optional feature macro: PARITY_CHECK_EN. When defined, window bit 1 is a
// parity bit checked against ODD_PARITY; when undefined, it is a second stop bit.
module serial_frame_decoder #(
  parameter int FRAME_W    = 11,
  parameter int FIFO_DEPTH = 4,
  parameter int ODD_PARITY = 0,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bit_strobe,
  input  logic [FRAME_W-1:0]   frame_in,
  output logic [7:0]           out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ERR_CNT_W-1:0] frame_err,
  output logic [ERR_CNT_W-1:0] parity_err,
  output logic                 overflow
);

  import serial_frame_pkg::*;

  if (FRAME_W != 11) begin : g_bad_frame_w
    $error("serial_frame_decoder: FRAME_W must be 11");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("serial_frame_decoder: FIFO_DEPTH must be a power of 2 and at least 2");
  end

  dec_state_t         state;
  logic [3:0]         bit_cnt;
  logic [FRAME_W-1:0] frame_q;
  logic               framing_bad;
  logic               par_bad;
  logic               push_req;
  logic               pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [7:0]         push_byte;

`ifdef PARITY_CHECK_EN
  assign framing_bad = frame_q[START_IDX] || !frame_q[STOP_IDX];
  assign par_bad     = (^frame_q[DATA_MSB_IDX:PAR_IDX]) != ODD_PARITY[0];
`else
  assign framing_bad = frame_q[START_IDX] || !frame_q[STOP_IDX] || !frame_q[PAR_IDX];
  assign par_bad     = 1'b0;
`endif

  assign push_req  = (state == CHECK) && !framing_bad && !par_bad;
  assign push_byte = reverse8(frame_q[DATA_MSB_IDX:DATA_LSB_IDX]);
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (push_byte),
    .pop   (pop),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Frame tracking FSM plus frame error counter and sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      bit_cnt   <= '0;
      frame_q   <= '0;
      frame_err <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        HUNT: begin
          if (bit_strobe && !frame_in[STOP_IDX]) begin
            state   <= COLLECT;
            bit_cnt <= 4'd1;
          end
        end
        COLLECT: begin
          if (bit_strobe) begin
            if (bit_cnt == 4'd10) begin
              state   <= CHECK;
              bit_cnt <= 4'd11;
              frame_q <= frame_in;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        CHECK: begin
          state   <= HUNT;
          bit_cnt <= '0;
          if (framing_bad && (frame_err != '1)) begin
            frame_err <= frame_err + 1'b1;
          end
          if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
          end
        end
        default: begin
          state   <= HUNT;
          bit_cnt <= '0;
        end
      endcase
    end
  end

`ifdef PARITY_CHECK_EN
  logic [ERR_CNT_W-1:0] parity_cnt;

  // Saturating count of frames whose framing was fine but parity failed.
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_cnt <= '0;
    end else if (state == CHECK && !framing_bad && par_bad && (parity_cnt != '1)) begin
      parity_cnt <= parity_cnt + 1'b1;
    end
  end

  assign parity_err = parity_cnt;
`else
  logic unused_odd_parity;
  assign unused_odd_parity = ODD_PARITY[0];
  assign parity_err        = '0;
`endif

endmodule

// File: tb/tb_serial_frame_decoder.sv
// Directed testbench for serial_frame_decoder. Frames are shifted into a
// model of the upstream shift register one bit per strobe, with strobes
// two clocks apart. Outputs are sampled on the falling clock edge.
module tb_serial_frame_decoder;

  logic        clk;
  logic        reset;
  logic        bit_strobe;
  logic [10:0] frame_in;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  frame_err;
  logic [7:0]  parity_err;
  logic        overflow;

  int tests_run = 0;
  int failures  = 0;

  serial_frame_decoder #(
    .FRAME_W    (11),
    .FIFO_DEPTH (4),
    .ODD_PARITY (0),
    .ERR_CNT_W  (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bit_strobe (bit_strobe),
    .frame_in   (frame_in),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overflow   (overflow)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Bit that makes a frame valid in window position 1 for this build.
  function automatic logic good_par(input logic [7:0] b);
`ifdef PARITY_CHECK_EN
    return ^b;
`else
    return 1'b1;
`endif
  endfunction

  task automatic send_bit(input logic b);
    @(negedge clk);
    frame_in   = {frame_in[9:0], b};
    bit_strobe = 1'b1;
    @(negedge clk);
    bit_strobe = 1'b0;
  endtask

  // Returns during the CHECK cycle of the frame.
  task automatic send_frame(input logic [7:0] b, input logic p, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(b[i]);
    end
    send_bit(p);
    send_bit(stop);
  endtask

  // Returns once the CHECK cycle has completed.
  task automatic send_good(input logic [7:0] b);
    send_frame(b, good_par(b), 1'b1);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    bit_strobe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] exp5 [4];
    exp5[0] = 8'h21;
    exp5[1] = 8'h22;
    exp5[2] = 8'h23;
    exp5[3] = 8'h55;

    reset      = 1'b1;
    bit_strobe = 1'b0;
    frame_in   = '1;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    check_output("rst_valid", out_valid, 0);
    check_output("rst_data", out_data, 8'h00);
    check_output("rst_frame_err", frame_err, 0);
    check_output("rst_parity_err", parity_err, 0);
    check_output("rst_overflow", overflow, 0);

    // 1: idle line then a good 0xA5, latency of two clocks after the last strobe
    repeat (20) send_bit(1'b1);
    check_output("t1_idle_valid", out_valid, 0);
    send_frame(8'hA5, good_par(8'hA5), 1'b1);
    check_output("t1_valid_early", out_valid, 0);
    @(negedge clk);
    check_output("t1_valid", out_valid, 1);
    check_output("t1_data", out_data, 8'hA5);
    check_output("t1_frame_err", frame_err, 0);
    check_output("t1_parity_err", parity_err, 0);
    pop_one();
    check_output("t1_popped", out_valid, 0);

    // 2: bad stop bit, then a good frame proves the FSM returned to HUNT
    send_frame(8'h3C, good_par(8'h3C), 1'b0);
    @(negedge clk);
    check_output("t2_frame_err", frame_err, 1);
    check_output("t2_valid", out_valid, 0);
    send_good(8'h5A);
    check_output("t2_recover_valid", out_valid, 1);
    check_output("t2_recover_data", out_data, 8'h5A);
    pop_one();

    // 3: window bit 1 cleared on 0x01
    send_frame(8'h01, 1'b0, 1'b1);
    @(negedge clk);
`ifdef PARITY_CHECK_EN
    check_output("t3_parity_err", parity_err, 1);
    check_output("t3_frame_err", frame_err, 1);
`else
    check_output("t3_parity_err", parity_err, 0);
    check_output("t3_frame_err", frame_err, 2);
`endif
    check_output("t3_valid", out_valid, 0);

    // 4: five bytes into a four-entry FIFO with the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_good(8'h10 + 8'(i));
      if (i == 3) check_output("t4_no_overflow", overflow, 0);
    end
    check_output("t4_overflow", overflow, 1);
    for (int i = 0; i < 4; i++) begin
      check_output("t4_drain_valid", out_valid, 1);
      check_output("t4_drain_data", out_data, 8'h10 + 32'(i));
      pop_one();
    end
    check_output("t4_empty", out_valid, 0);

    // 5: full FIFO, pop and push in the same CHECK cycle
    do_reset();
    check_output("t5_overflow_clr", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      send_good(8'h20 + 8'(i));
    end
    check_output("t5_full_valid", out_valid, 1);
    send_frame(8'h55, good_par(8'h55), 1'b1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_output("t5_overflow", overflow, 0);
    for (int i = 0; i < 4; i++) begin
      check_output("t5_drain_data", out_data, exp5[i]);
      pop_one();
    end
    check_output("t5_empty", out_valid, 0);

    // 6: reset in the middle of a frame with data and errors present
    send_good(8'h66);
    send_frame(8'h00, good_par(8'h00), 1'b0);
    @(negedge clk);
    check_output("t6_pre_frame_err", frame_err, 1);
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    do_reset();
    check_output("t6_valid", out_valid, 0);
    check_output("t6_data", out_data, 8'h00);
    check_output("t6_frame_err", frame_err, 0);
    check_output("t6_parity_err", parity_err, 0);
    check_output("t6_overflow", overflow, 0);
    send_good(8'hFF);
    check_output("t6_ff_valid", out_valid, 1);
    check_output("t6_ff_data", out_data, 8'hFF);
    pop_one();
    repeat (300) begin
      send_frame(8'h00, good_par(8'h00), 1'b0);
      @(negedge clk);
    end
    check_output("t6_saturate", frame_err, 8'hFF);
    check_output("t6_sat_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
